// File: rtl/gray_stream_checker.sv
// Registered Gray-code stream decoder and step-integrity monitor.
// It classifies each valid sample against the previous one and tracks illegal transitions.
module gray_stream_checker #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_gray_valid,
    input  logic [WIDTH-1:0]     i_gray_in,
    input  logic                 i_clear,
    output logic [WIDTH-1:0]     o_bin_out,
    output logic                 o_bin_valid,
    output logic                 o_step_up,
    output logic                 o_step_down,
    output logic                 o_step_hold,
    output logic                 o_step_err,
    output logic                 o_err_sticky,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    typedef enum logic {EMPTY, TRACK} state_t;

    localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    state_t               r_state;
    logic [WIDTH-1:0]     r_prev_bin;
    logic [WIDTH-1:0]     w_new_bin;
    logic                 w_is_hold;
    logic                 w_is_up;
    logic                 w_is_down;

    // Prefix-XOR from the MSB down turns Gray into binary.
    always_comb begin
        w_new_bin = '0;
        w_new_bin[WIDTH-1] = i_gray_in[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--)
            w_new_bin[i] = w_new_bin[i+1] ^ i_gray_in[i];
    end

    assign w_is_hold = (w_new_bin == r_prev_bin);
    assign w_is_up   = (w_new_bin == r_prev_bin + ONE);
    assign w_is_down = (w_new_bin == r_prev_bin - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_prev_bin   <= '0;
            o_bin_out    <= '0;
            o_bin_valid  <= 1'b0;
            o_step_up    <= 1'b0;
            o_step_down  <= 1'b0;
            o_step_hold  <= 1'b0;
            o_step_err   <= 1'b0;
            o_err_sticky <= 1'b0;
            o_err_count  <= '0;
        end else begin
            o_bin_valid <= 1'b0;
            o_step_up   <= 1'b0;
            o_step_down <= 1'b0;
            o_step_hold <= 1'b0;
            o_step_err  <= 1'b0;
            // Clear wins over a coincident sample; bin_out deliberately keeps its value.
            if (i_clear) begin
                r_state      <= EMPTY;
                o_err_sticky <= 1'b0;
                o_err_count  <= '0;
            end else if (i_gray_valid) begin
                r_prev_bin  <= w_new_bin;
                o_bin_out   <= w_new_bin;
                o_bin_valid <= 1'b1;
                r_state     <= TRACK;
                if (r_state == TRACK) begin
                    if (w_is_hold)
                        o_step_hold <= 1'b1;
                    else if (w_is_up)
                        o_step_up <= 1'b1;
                    else if (w_is_down)
                        o_step_down <= 1'b1;
                    else begin
                        o_step_err   <= 1'b1;
                        o_err_sticky <= 1'b1;
                        if (o_err_count != CNT_MAX)
                            o_err_count <= o_err_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_stream_checker.sv
// Directed bench for gray_stream_checker with a 2-bit error counter to reach saturation.
module tb_gray_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_gray_valid;
    logic [3:0] i_gray_in;
    logic       i_clear;
    logic [3:0] o_bin_out;
    logic       o_bin_valid, o_step_up, o_step_down, o_step_hold, o_step_err, o_err_sticky;
    logic [1:0] o_err_count;

    int total = 0;
    int bad   = 0;

    gray_stream_checker #(.WIDTH(4), .ERR_CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_gray_valid (i_gray_valid),
        .i_gray_in    (i_gray_in),
        .i_clear      (i_clear),
        .o_bin_out    (o_bin_out),
        .o_bin_valid  (o_bin_valid),
        .o_step_up    (o_step_up),
        .o_step_down  (o_step_down),
        .o_step_hold  (o_step_hold),
        .o_step_err   (o_step_err),
        .o_err_sticky (o_err_sticky),
        .o_err_count  (o_err_count)
    );

    always #5 clk = ~clk;

    // flags = {bin_valid, up, down, hold, err}
    task automatic chk(input string tag, input logic [3:0] b, input logic [4:0] flags,
                       input logic sticky, input logic [1:0] cnt);
        logic [11:0] obs, exp;
        obs = {o_bin_out, o_bin_valid, o_step_up, o_step_down, o_step_hold, o_step_err,
               o_err_sticky, o_err_count};
        exp = {b, flags, sticky, cnt};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got bin/bv,up,dn,hold,err/sticky/cnt=%b required %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] g, input logic c);
        i_gray_valid = v;
        i_gray_in    = g;
        i_clear      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; i_gray_valid = 1'b0; i_gray_in = '0; i_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 4'd0, 5'b00000, 1'b0, 2'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Incrementing stream
        cyc(1, 4'b0000, 0); chk("first_ref",  4'd0, 5'b10000, 0, 2'd0);
        cyc(1, 4'b0001, 0); chk("up_1",       4'd1, 5'b11000, 0, 2'd0);
        cyc(1, 4'b0011, 0); chk("up_2",       4'd2, 5'b11000, 0, 2'd0);
        cyc(1, 4'b0010, 0); chk("up_3",       4'd3, 5'b11000, 0, 2'd0);

        // Clear keeps bin_out, then wrap-around both ways
        cyc(0, 4'b0000, 1); chk("clear_hold", 4'd3, 5'b00000, 0, 2'd0);
        cyc(1, 4'b1000, 0); chk("ref_15",     4'd15, 5'b10000, 0, 2'd0);
        cyc(1, 4'b0000, 0); chk("wrap_up",    4'd0, 5'b11000, 0, 2'd0);
        cyc(1, 4'b1000, 0); chk("wrap_down",  4'd15, 5'b10100, 0, 2'd0);
        cyc(1, 4'b0000, 0); chk("wrap_up2",   4'd0, 5'b11000, 0, 2'd0);

        // Illegal jump then resync
        cyc(1, 4'b0100, 0); chk("illegal_7",  4'd7, 5'b10001, 1, 2'd1);
        cyc(1, 4'b0101, 0); chk("resync_dn",  4'd6, 5'b10100, 1, 2'd1);

        // Repeat with idle gaps
        cyc(1, 4'b0011, 0); chk("jump_2",     4'd2, 5'b10001, 1, 2'd2);
        cyc(0, 4'b1111, 0); chk("idle_1",     4'd2, 5'b00000, 1, 2'd2);
        cyc(0, 4'b0101, 0); chk("idle_2",     4'd2, 5'b00000, 1, 2'd2);
        cyc(1, 4'b0011, 0); chk("hold",       4'd2, 5'b10010, 1, 2'd2);

        // Saturation of 2-bit counter
        cyc(0, 4'b0000, 1); chk("clear_2",    4'd2, 5'b00000, 0, 2'd0);
        cyc(1, 4'b0000, 0); chk("sat_ref",    4'd0, 5'b10000, 0, 2'd0);
        cyc(1, 4'b0100, 0); chk("sat_e1",     4'd7, 5'b10001, 1, 2'd1);
        cyc(1, 4'b0000, 0); chk("sat_e2",     4'd0, 5'b10001, 1, 2'd2);
        cyc(1, 4'b0100, 0); chk("sat_e3",     4'd7, 5'b10001, 1, 2'd3);
        cyc(1, 4'b0000, 0); chk("sat_e4",     4'd0, 5'b10001, 1, 2'd3);
        cyc(1, 4'b0100, 0); chk("sat_e5",     4'd7, 5'b10001, 1, 2'd3);
        cyc(1, 4'b0001, 1); chk("clear_prio", 4'd7, 5'b00000, 0, 2'd0);
        cyc(1, 4'b0001, 0); chk("after_clr",  4'd1, 5'b10000, 0, 2'd0);
        cyc(1, 4'b0011, 0); chk("pre_rst_up", 4'd2, 5'b11000, 0, 2'd0);

        // Asynchronous reset between edges
        i_gray_valid = 1'b0;
        @(negedge clk); rst_n = 1'b0; #1;
        chk("async_rst", 4'd0, 5'b00000, 0, 2'd0);
        @(negedge clk); rst_n = 1'b1;
        cyc(1, 4'b0110, 0); chk("rst_ref",    4'd4, 5'b10000, 0, 2'd0);
        cyc(1, 4'b0111, 0); chk("rst_up",     4'd5, 5'b11000, 0, 2'd0);
        cyc(0, 4'b0000, 0); chk("final_idle", 4'd5, 5'b00000, 0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
